// File: rtl/player_direction_ctrl.sv
// Per-player steering: parses PS/2 make/break/extended bytes against the mapped direction
// codes, tracks held keys, and commits the requested turn to the bike heading on game ticks.
module player_direction_ctrl #(
  parameter logic [1:0]  INIT_DIR       = 2'b01,
  parameter int unsigned PREFIX_TIMEOUT = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic [7:0] left_code,
  input  logic [7:0] right_code,
  input  logic [7:0] up_code,
  input  logic [7:0] down_code,
  input  logic       game_tick,
  input  logic       enable,
  output logic [1:0] direction,
  output logic       dir_changed,
  output logic [3:0] key_held
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExt  = 2'd1;
  localparam logic [1:0] StBrk  = 2'd2;

  localparam logic [7:0]       CodeExt    = 8'hE0;
  localparam logic [7:0]       CodeBrk    = 8'hF0;
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(PREFIX_TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       direction_q, direction_d;
  logic             dir_changed_q, dir_changed_d;
  logic [3:0]       key_held_q, key_held_d;
  logic [1:0]       pending_dir_q, pending_dir_d;
  logic             pending_valid_q, pending_valid_d;

  logic       make_evt, brk_evt, timeout_hit;
  logic       hit;
  logic [3:0] hit_bit;
  logic [1:0] hit_dir;

  assign timeout_hit = (cnt_q == TimeoutVal);

  // Byte parser; the idle counter only runs while a prefix is waiting for its code byte.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (scan_valid) begin
          if (scan_code == CodeExt) begin
            state_d = StExt;
          end else if (scan_code == CodeBrk) begin
            state_d = StBrk;
          end else begin
            make_evt = 1'b1;
          end
        end
      end
      StExt: begin
        if (scan_valid) begin
          cnt_d = '0;
          if (scan_code == CodeBrk) begin
            state_d = StBrk;
          end else begin
            make_evt = 1'b1;
            state_d  = StIdle;
          end
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StBrk: begin
        if (scan_valid) begin
          cnt_d   = '0;
          brk_evt = 1'b1;
          state_d = StIdle;
        end else if (timeout_hit) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Colliding mappings resolve up > right > down > left.
  always_comb begin
    hit     = 1'b1;
    hit_bit = 4'b0000;
    hit_dir = 2'b00;
    if (scan_code == up_code) begin
      hit_bit = 4'b0001;
      hit_dir = 2'b00;
    end else if (scan_code == right_code) begin
      hit_bit = 4'b0010;
      hit_dir = 2'b01;
    end else if (scan_code == down_code) begin
      hit_bit = 4'b0100;
      hit_dir = 2'b10;
    end else if (scan_code == left_code) begin
      hit_bit = 4'b1000;
      hit_dir = 2'b11;
    end else begin
      hit = 1'b0;
    end
  end

  always_comb begin
    key_held_d      = key_held_q;
    direction_d     = direction_q;
    dir_changed_d   = 1'b0;
    pending_dir_d   = pending_dir_q;
    pending_valid_d = pending_valid_q;

    if (make_evt && hit) begin
      key_held_d = key_held_q | hit_bit;
    end else if (brk_evt && hit) begin
      key_held_d = key_held_q & ~hit_bit;
    end

    // Commit uses the value pending before this edge; a reversal is silently dropped.
    if (enable && game_tick && pending_valid_q) begin
      pending_valid_d = 1'b0;
      if (((pending_dir_q ^ direction_q) != 2'b10) && (pending_dir_q != direction_q)) begin
        direction_d   = pending_dir_q;
        dir_changed_d = 1'b1;
      end
    end

    if (make_evt && hit) begin
      pending_dir_d   = hit_dir;
      pending_valid_d = 1'b1;
    end

    if (!enable) begin
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      direction_q     <= INIT_DIR;
      dir_changed_q   <= 1'b0;
      key_held_q      <= 4'b0000;
      pending_dir_q   <= 2'b00;
      pending_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      direction_q     <= direction_d;
      dir_changed_q   <= dir_changed_d;
      key_held_q      <= key_held_d;
      pending_dir_q   <= pending_dir_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  assign direction   = direction_q;
  assign dir_changed = dir_changed_q;
  assign key_held    = key_held_q;

endmodule

// File: tb/tb_player_direction_ctrl.sv
// Directed bench for player_direction_ctrl: the driver queues the expected outputs of every
// stimulus cycle and an independent monitor pops and compares them one cycle at a time.
module tb_player_direction_ctrl;

  logic       clock = 1'b0;
  logic       reset, scan_valid, game_tick, enable;
  logic [7:0] scan_code, left_code, right_code, up_code, down_code;
  logic [1:0] direction;
  logic       dir_changed;
  logic [3:0] key_held;

  always #5 clock = ~clock;

  player_direction_ctrl #(
    .INIT_DIR      (2'b01),
    .PREFIX_TIMEOUT(40),
    .CNT_W         (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .left_code  (left_code),
    .right_code (right_code),
    .up_code    (up_code),
    .down_code  (down_code),
    .game_tick  (game_tick),
    .enable     (enable),
    .direction  (direction),
    .dir_changed(dir_changed),
    .key_held   (key_held)
  );

  typedef struct {
    logic [1:0] d;
    logic       c;
    logic [3:0] h;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input string fld, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
    end
  endtask

  // Outputs settle after posedge; the monitor samples on the following negedge.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, "direction", {2'b00, direction}, {2'b00, mon_e.d});
      chk(mon_e.name, "dir_changed", {3'b000, dir_changed}, {3'b000, mon_e.c});
      chk(mon_e.name, "key_held", key_held, mon_e.h);
    end
  end

  task automatic step(input logic v, input logic [7:0] c, input logic t, input logic [1:0] ed,
                      input logic ec, input logic [3:0] eh, input string nm);
    exp_t e;
    @(negedge clock);
    scan_valid = v;
    scan_code  = c;
    game_tick  = t;
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
    game_tick  = 1'b0;
    e.d = ed;
    e.c = ec;
    e.h = eh;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] c, input logic [1:0] ed, input logic [3:0] eh,
                      input string nm);
    step(1'b1, c, 1'b0, ed, 1'b0, eh, nm);
  endtask

  task automatic tick(input logic [1:0] ed, input logic ec, input logic [3:0] eh,
                      input string nm);
    step(1'b0, 8'h00, 1'b1, ed, ec, eh, nm);
  endtask

  task automatic idle(input int n, input logic [1:0] ed, input logic [3:0] eh,
                      input string nm);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, ed, 1'b0, eh, nm);
  endtask

  task automatic keyset0();
    up_code = 8'h1D; left_code = 8'h1C; down_code = 8'h1B; right_code = 8'h23;
  endtask

  // Turn right from a non-left heading and release the key again.
  task automatic go_right(input logic [1:0] cur);
    send(8'h23, cur, 4'b0010, "gr_mk");
    tick(2'b01, 1'b1, 4'b0010, "gr_tick");
    send(8'hF0, 2'b01, 4'b0010, "gr_f0");
    send(8'h23, 2'b01, 4'b0000, "gr_brk");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; game_tick = 1'b0; enable = 1'b1;
    keyset0();

    step(1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 4'b0000, "rst");
    reset = 1'b0;
    idle(10, 2'b01, 4'b0000, "rst_hold");

    send(8'h1D, 2'b01, 4'b0001, "mk_up");
    tick(2'b00, 1'b1, 4'b0001, "tick_up");
    idle(1, 2'b00, 4'b0001, "chg_pulse");
    send(8'hF0, 2'b00, 4'b0001, "brk_pref");
    send(8'h1D, 2'b00, 4'b0000, "brk_up");

    go_right(2'b00);
    send(8'h1C, 2'b01, 4'b1000, "mk_left");
    tick(2'b01, 1'b0, 4'b1000, "rev_rej");
    tick(2'b01, 1'b0, 4'b1000, "rev_2nd");
    send(8'hF0, 2'b01, 4'b1000, "left_f0");
    send(8'h1C, 2'b01, 4'b0000, "left_brk");

    up_code = 8'h75; left_code = 8'h6B; down_code = 8'h72; right_code = 8'h74;
    send(8'hE0, 2'b01, 4'b0000, "ext_pref");
    send(8'h75, 2'b01, 4'b0001, "ext_mk");
    send(8'hE0, 2'b01, 4'b0001, "ext_pref2");
    send(8'hF0, 2'b01, 4'b0001, "ext_f0");
    send(8'h75, 2'b01, 4'b0000, "ext_brk");
    tick(2'b00, 1'b1, 4'b0000, "ext_tick");
    keyset0();

    go_right(2'b00);
    send(8'h1D, 2'b01, 4'b0001, "lw_up");
    send(8'h1B, 2'b01, 4'b0101, "lw_down");
    tick(2'b10, 1'b1, 4'b0101, "last_wins");
    send(8'hF0, 2'b10, 4'b0101, "lw_f0a");
    send(8'h1D, 2'b10, 4'b0100, "lw_brk_up");
    send(8'hF0, 2'b10, 4'b0100, "lw_f0b");
    send(8'h1B, 2'b10, 4'b0000, "lw_brk_down");
    send(8'h1B, 2'b10, 4'b0100, "same_mk");
    tick(2'b10, 1'b0, 4'b0100, "same_dir");
    send(8'hF0, 2'b10, 4'b0100, "same_f0");
    send(8'h1B, 2'b10, 4'b0000, "same_brk");

    go_right(2'b10);
    send(8'hF0, 2'b01, 4'b0000, "to_pref");
    idle(42, 2'b01, 4'b0000, "to_wait");
    send(8'h1D, 2'b01, 4'b0001, "to_mk");
    tick(2'b00, 1'b1, 4'b0001, "to_tick");
    send(8'hF0, 2'b00, 4'b0001, "short_f0");
    idle(10, 2'b00, 4'b0001, "short_wait");
    send(8'h1D, 2'b00, 4'b0000, "short_brk");

    go_right(2'b00);
    step(1'b1, 8'h1D, 1'b1, 2'b01, 1'b0, 4'b0001, "mk_tick_same");
    tick(2'b00, 1'b1, 4'b0001, "mk_tick_next");
    send(8'hF0, 2'b00, 4'b0001, "mts_f0");
    send(8'h1D, 2'b00, 4'b0000, "mts_brk");

    go_right(2'b00);
    enable = 1'b0;
    send(8'h1D, 2'b01, 4'b0001, "dis_mk");
    enable = 1'b1;
    tick(2'b01, 1'b0, 4'b0001, "dis_tick");
    send(8'hF0, 2'b01, 4'b0001, "dis_f0");
    send(8'h1D, 2'b01, 4'b0000, "dis_brk");

    send(8'h1B, 2'b01, 4'b0100, "rm_down");
    send(8'hF0, 2'b01, 4'b0100, "rm_f0");
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 2'b01, 1'b0, 4'b0000, "rst_mid");
    reset = 1'b0;
    send(8'h1D, 2'b01, 4'b0001, "rst_mk");
    tick(2'b00, 1'b1, 4'b0001, "rst_tick");
    send(8'hF0, 2'b00, 4'b0001, "rst_f0");
    send(8'h1D, 2'b00, 4'b0000, "rst_brk");

    go_right(2'b00);
    right_code = 8'h1D;
    send(8'h1D, 2'b01, 4'b0001, "prio_mk");
    tick(2'b00, 1'b1, 4'b0001, "prio_tick");
    send(8'hF0, 2'b00, 4'b0001, "prio_f0");
    send(8'h1D, 2'b00, 4'b0000, "prio_brk");
    right_code = 8'h23;

    send(8'h1D, 2'b00, 4'b0001, "remap_mk");
    up_code = 8'h75;
    send(8'hF0, 2'b00, 4'b0001, "remap_f0");
    send(8'h1D, 2'b00, 4'b0001, "remap_stale");
    send(8'hF0, 2'b00, 4'b0001, "remap_f0b");
    send(8'h75, 2'b00, 4'b0000, "remap_brk");

    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
